// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes, memory-wait freeze
// with a timeout trap, plus saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WCNT_W = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic              freeze_c;
  logic              load_use_c;
  logic [WCNT_W-1:0] wait_idx_c;
  logic              hit_timeout_c;

  // Hazard detection from current inputs.
  always_comb begin
    freeze_c   = mem_req & ~mem_ready;
    load_use_c = ex_mem_read & (ex_rd != 5'd0) &
                 ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  end

  // Control outputs by priority; a frozen pipeline defers redirects and load-use.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    if (!reset) begin
      if ((state_q == ERROR) || freeze_c) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (load_use_c) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_flush  = 1'b1;
      end
    end
  end

  // Wait-state FSM; the entry cycle from RUN counts as wait cycle index 0.
  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    wait_idx_c    = (state_q == MEM_WAIT) ? wcnt_q : '0;
    hit_timeout_c = freeze_c & (state_q != ERROR) & (wait_idx_c == WCNT_W'(TIMEOUT - 1));
    mem_timeout_d = mem_timeout_q | hit_timeout_c;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (hit_timeout_c) begin
          state_d = ERROR;
          wcnt_d  = '0;
        end else if (freeze_c) begin
          state_d = MEM_WAIT;
          wcnt_d  = wait_idx_c + WCNT_W'(1);
        end else begin
          state_d = RUN;
          wcnt_d  = '0;
        end
      end
      ERROR:   state_d = ERROR;
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (id_ex_flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wcnt_q        <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central producer of the stall and flush controls consumed by the pipeline registers: pc, if_id, id_ex, ex_mem and mem_wb.
- Detects load-use hazards in ID and branch/jump redirects from EX.
- Freezes the whole pipeline while data memory holds off an access.
- Keeps a wait-state FSM with a timeout, plus saturating stall and flush performance counters.

Parameters:
- TIMEOUT, 255: max consecutive memory wait cycles before the error trap.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_rs1  in  5  rs1 of instruction in ID
- id_rs2  in  5  rs2 of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination register of instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- ex_redirect  in  1  EX resolved a taken branch or jump
- mem_req  in  1  MEM stage holds a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  bubble IF/ID
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  bubble ID/EX
- ex_mem_stall  out  1  hold EX/MEM
- mem_wb_flush  out  1  bubble MEM/WB
- mem_timeout  out  1  sticky error flag
- stall_cnt  out  CNT_W  cycles with pc_stall=1
- flush_cnt  out  CNT_W  cycles with id_ex_flush=1

Behaviour:
- Pipeline registers apply reset > flush > stall. This block therefore never asserts stall and flush for the same register in the same cycle.
- freeze = mem_req & !mem_ready, evaluated combinationally from current inputs.
- load_use = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- FSM states: RUN, MEM_WAIT, ERROR. Reset state is RUN. Wait counter wcnt is 8 bits, reset value 0.
- Transitions:
  - RUN -> MEM_WAIT when freeze.
  - MEM_WAIT -> RUN when mem_ready; wcnt clears.
  - MEM_WAIT stays while freeze; wcnt increments.
  - MEM_WAIT -> ERROR when freeze and wcnt == TIMEOUT-1, i.e. the TIMEOUT-th consecutive wait cycle. mem_timeout goes to 1 on the next edge.
  - ERROR is left only via reset.
- Output priority, highest first, all combinational from current state and inputs:
  1. state==ERROR, or freeze (in any state): pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; mem_wb_flush = 1; all other flushes = 0. A redirect or load-use is ignored while frozen; the EX/ID contents hold, so these are re-evaluated once the freeze lifts.
  2. ex_redirect: if_id_flush = 1, id_ex_flush = 1; all stalls = 0. This overrides load-use, because the ID instruction is squashed.
  3. load_use: pc_stall = 1, if_id_stall = 1, id_ex_flush = 1 (one bubble); the other outputs are 0.
  4. Otherwise every output is 0.
- Load-use lasts exactly 1 cycle per hazard: the next cycle the load is in MEM, and its stall is handled by freeze if mem_ready is late.
- Reset values: all stall and flush outputs 0, mem_timeout 0, stall_cnt 0, flush_cnt 0.
- While reset=1 the control outputs are forced to 0 regardless of inputs.
- Counters increment on each clock edge where their condition is true. They saturate at all-ones and never wrap.
- mem_ready with mem_req=0 is ignored.
- A reset mid-MEM_WAIT or in ERROR returns to RUN, clears wcnt, mem_timeout and both counters in the same edge.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for 1 cycle -> pc_stall=1, if_id_stall=1, id_ex_flush=1, others 0; stall_cnt=1 and flush_cnt=1 afterwards. Repeat with ex_rd=0 -> all 0.
- Redirect plus load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_stall=0; stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1:
  - during the 3 wait cycles: freeze outputs (four stalls and mem_wb_flush = 1);
  - FSM RUN -> MEM_WAIT -> RUN;
  - stall_cnt=3; outputs 0 in the ready cycle.
- Redirect held during a freeze: ex_redirect=1 with freeze for 2 cycles, then mem_ready=1 -> no flush during the freeze; if_id_flush=id_ex_flush=1 in the ready cycle.
- Timeout, TIMEOUT=4:
  - freeze held 4 cycles -> mem_timeout=1 after the 4th edge, and freeze outputs stay asserted after mem_req drops;
  - reset=1 for 1 cycle -> mem_timeout=0, state RUN, counters 0.
- Saturation, CNT_W=4: 20 consecutive load-use cycles -> stall_cnt=15 and held at 15.
